// File: rtl/lk_destport_queue_pkg.sv
// Shared definitions for the look-ahead destination-port queue:
// NoC parameter defaults, the width helper and the per-cycle FIFO operation code.
package lk_destport_queue_pkg;

  localparam int V_DEF       = 4;
  localparam int DSTPW_DEF   = 4;
  localparam int MAX_PKT_DEF = 4;

  // Ceiling log2; callers size counters as log2(n+1) so that n itself is representable.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/lk_destport_queue_destport_fifo.sv
// Single-VC route FIFO: holds one look-ahead destport per packet resident in the VC buffer,
// with sticky overflow/underflow flags.
module destport_fifo
  import lk_destport_queue_pkg::*;
#(
  parameter int DSTPw   = DSTPW_DEF,
  parameter int MAX_PKT = MAX_PKT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DSTPw-1:0] din,
  output logic [DSTPw-1:0] head,
  output logic             vld,
  output logic             ovf,
  output logic             udf
);

  localparam int PW = (log2(MAX_PKT) < 1) ? 1 : log2(MAX_PKT);
  localparam int CW = log2(MAX_PKT + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_PKT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PKT);

  logic [DSTPw-1:0] mem [MAX_PKT];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  fifo_op_e         op;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop on a full queue frees the slot the same-cycle push lands in; a push is never
  // forwarded to a same-cycle pop, so popping an empty queue is always an underflow.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign op      = fifo_op_e'({do_push, do_pop});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MAX_PKT; k++) mem[k] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push & full & ~pop) ovf <= 1'b1;
      if (pop & empty)        udf <= 1'b1;
    end
  end

  assign head = mem[rd_ptr];
  assign vld  = ~empty;

endmodule

// File: rtl/lk_destport_queue.sv
// Per-input-port look-ahead destport queue: one route FIFO per VC, pushed on header
// writes and retired when the packet's tail flit is read from the VC buffer.
module lk_destport_queue
  import lk_destport_queue_pkg::*;
#(
  parameter int V       = V_DEF,
  parameter int DSTPw   = DSTPW_DEF,
  parameter int MAX_PKT = MAX_PKT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flit_in_wr,
  input  logic [V-1:0]       vc_num_in,
  input  logic               hdr_flg_in,
  input  logic [DSTPw-1:0]   lkdestport_in,
  input  logic [V-1:0]       ivc_rd,
  input  logic               tail_flg_out,
  output logic [V*DSTPw-1:0] destport_out,
  output logic [V-1:0]       destport_vld,
  output logic [V-1:0]       ovf_err,
  output logic [V-1:0]       udf_err
);

  logic [V-1:0] push_vc;
  logic [V-1:0] pop_vc;

  // Non-one-hot VC selects act on every asserted VC; upstream guarantees one-hot.
  assign push_vc = {V{flit_in_wr & hdr_flg_in}} & vc_num_in;
  assign pop_vc  = {V{tail_flg_out}} & ivc_rd;

  for (genvar i = 0; i < V; i++) begin : g_vc
    destport_fifo #(
      .DSTPw  (DSTPw),
      .MAX_PKT(MAX_PKT)
    ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push_vc[i]),
      .pop  (pop_vc[i]),
      .din  (lkdestport_in),
      .head (destport_out[i*DSTPw +: DSTPw]),
      .vld  (destport_vld[i]),
      .ovf  (ovf_err[i]),
      .udf  (udf_err[i])
    );
  end

endmodule

// File: tb/tb_lk_destport_queue.sv
// Scoreboard bench for lk_destport_queue: directed scenarios plus randomized traffic,
// checked against per-VC packet queues.
module tb_lk_destport_queue;

  localparam int V       = 4;
  localparam int DSTPw   = 4;
  localparam int MAX_PKT = 4;

  logic               clk;
  logic               reset;
  logic               flit_in_wr;
  logic [V-1:0]       vc_num_in;
  logic               hdr_flg_in;
  logic [DSTPw-1:0]   lkdestport_in;
  logic [V-1:0]       ivc_rd;
  logic               tail_flg_out;
  logic [V*DSTPw-1:0] destport_out;
  logic [V-1:0]       destport_vld;
  logic [V-1:0]       ovf_err;
  logic [V-1:0]       udf_err;

  typedef struct {
    logic [V-1:0]       vld;
    logic [V-1:0]       ovf;
    logic [V-1:0]       udf;
    logic [V*DSTPw-1:0] dp;
  } exp_t;

  exp_t sb [$];
  int   mq [V][$];
  logic [V-1:0] m_ovf;
  logic [V-1:0] m_udf;
  int   checks;
  int   failures;
  int   cycle;

  lk_destport_queue #(
    .V      (V),
    .DSTPw  (DSTPw),
    .MAX_PKT(MAX_PKT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flit_in_wr   (flit_in_wr),
    .vc_num_in    (vc_num_in),
    .hdr_flg_in   (hdr_flg_in),
    .lkdestport_in(lkdestport_in),
    .ivc_rd       (ivc_rd),
    .tail_flg_out (tail_flg_out),
    .destport_out (destport_out),
    .destport_vld (destport_vld),
    .ovf_err      (ovf_err),
    .udf_err      (udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Compares one observed output set against the expectation; heads are only
  // meaningful where the queue holds an entry.
  task automatic check_output(input exp_t e, input string tag);
    for (int i = 0; i < V; i++) begin
      checks++;
      if (destport_vld[i] !== e.vld[i]) begin
        failures++;
        $display("[TB] FAIL %s vld[%0d] cycle %0d: actual=%0b required=%0b", tag, i, cycle, destport_vld[i], e.vld[i]);
      end
      checks++;
      if (ovf_err[i] !== e.ovf[i]) begin
        failures++;
        $display("[TB] FAIL %s ovf[%0d] cycle %0d: actual=%0b required=%0b", tag, i, cycle, ovf_err[i], e.ovf[i]);
      end
      checks++;
      if (udf_err[i] !== e.udf[i]) begin
        failures++;
        $display("[TB] FAIL %s udf[%0d] cycle %0d: actual=%0b required=%0b", tag, i, cycle, udf_err[i], e.udf[i]);
      end
      if (e.vld[i]) begin
        checks++;
        if (destport_out[i*DSTPw +: DSTPw] !== e.dp[i*DSTPw +: DSTPw]) begin
          failures++;
          $display("[TB] FAIL %s destport[%0d] cycle %0d: actual=%0h required=%0h", tag, i, cycle,
                   destport_out[i*DSTPw +: DSTPw], e.dp[i*DSTPw +: DSTPw]);
        end
      end
    end
  endtask

  // Drives one cycle of inputs at the falling edge, advances the packet-queue model
  // and queues what the outputs must look like after the next rising edge.
  task automatic apply_stimulus(input logic wr, input logic [V-1:0] vc, input logic hdr,
                                input logic [DSTPw-1:0] dp, input logic [V-1:0] rd, input logic tail);
    exp_t e;
    @(negedge clk);
    flit_in_wr    = wr;
    vc_num_in     = vc;
    hdr_flg_in    = hdr;
    lkdestport_in = dp;
    ivc_rd        = rd;
    tail_flg_out  = tail;
    for (int i = 0; i < V; i++) begin
      bit push;
      bit pop;
      int sz;
      push = wr && hdr && vc[i];
      pop  = rd[i] && tail;
      sz   = mq[i].size();
      if (pop && sz == 0) m_udf[i] = 1'b1;
      if (push && sz == MAX_PKT && !pop) m_ovf[i] = 1'b1;
      if (pop && sz > 0) void'(mq[i].pop_front());
      if (push && (sz < MAX_PKT || pop)) mq[i].push_back(int'(dp));
    end
    e.ovf = m_ovf;
    e.udf = m_udf;
    e.dp  = '0;
    for (int i = 0; i < V; i++) begin
      e.vld[i] = (mq[i].size() > 0);
      if (mq[i].size() > 0) e.dp[i*DSTPw +: DSTPw] = DSTPw'(mq[i][0]);
    end
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    flit_in_wr    = 1'b0;
    vc_num_in     = '0;
    hdr_flg_in    = 1'b0;
    lkdestport_in = '0;
    ivc_rd        = '0;
    tail_flg_out  = 1'b0;
  endtask

  // Asserts reset between clock edges and checks that everything clears without a clock.
  task automatic do_reset();
    exp_t z;
    z.vld = '0;
    z.ovf = '0;
    z.udf = '0;
    z.dp  = '0;
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check_output(z, "reset");
    checks++;
    if (destport_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset destport_out: actual=%0h required=0", destport_out);
    end
    for (int i = 0; i < V; i++) mq[i].delete();
    m_ovf = '0;
    m_udf = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: pops one expectation per rising edge that the stimulus side scheduled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) check_output(sb.pop_front(), "scoreboard");
    end
  end

  initial begin
    logic [V-1:0] vc;
    logic [V-1:0] rd;
    int hdr_pct;
    int wait_cycles;
    checks   = 0;
    failures = 0;
    cycle    = 0;
    m_ovf    = '0;
    m_udf    = '0;
    reset    = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (destport_out !== '0 || destport_vld !== '0 || ovf_err !== '0 || udf_err !== '0) begin
      failures++;
      $display("[TB] FAIL power-on reset: actual out=%0h vld=%0b ovf=%0b udf=%0b required all 0",
               destport_out, destport_vld, ovf_err, udf_err);
    end
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] basic push on VC0");
    apply_stimulus(1, 4'b0001, 1, 4'b0010, 4'b0000, 0);
    apply_stimulus(0, 4'b0000, 0, 4'b0000, 4'b0000, 0);

    $display("[TB] multi-packet ordering on VC2");
    apply_stimulus(1, 4'b0100, 1, 4'd1, 4'b0000, 0);
    apply_stimulus(1, 4'b0100, 1, 4'd2, 4'b0000, 0);
    apply_stimulus(1, 4'b0100, 0, 4'd9, 4'b0100, 0);
    apply_stimulus(1, 4'b0100, 1, 4'd3, 4'b0100, 1);
    apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b0100, 1);
    apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b0100, 1);
    apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b0000, 0);

    $display("[TB] single-flit packet on VC3");
    apply_stimulus(1, 4'b1000, 1, 4'd7, 4'b0000, 1);
    apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b1000, 1);
    apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b0000, 0);

    $display("[TB] full and overflow on VC1");
    for (int k = 0; k < MAX_PKT; k++) apply_stimulus(1, 4'b0010, 1, DSTPw'(k + 4), 4'b0000, 0);
    apply_stimulus(1, 4'b0010, 1, 4'hF, 4'b0000, 0);
    apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b0000, 0);
    do_reset();
    for (int k = 0; k < MAX_PKT; k++) apply_stimulus(1, 4'b0010, 1, DSTPw'(k + 8), 4'b0000, 0);
    apply_stimulus(1, 4'b0010, 1, 4'hE, 4'b0010, 1);
    for (int k = 0; k < MAX_PKT; k++) apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b0010, 1);

    $display("[TB] underflow on VC3, push+pop on empty VC0");
    apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b1000, 1);
    apply_stimulus(1, 4'b0001, 1, 4'd5, 4'b0001, 1);
    apply_stimulus(0, 4'b0000, 0, 4'd0, 4'b0000, 0);
    apply_stimulus(1, 4'b0100, 1, 4'd6, 4'b0000, 0);
    do_reset();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 2000; k++) begin
      if (k % 250 == 249) do_reset();
      hdr_pct = ((k % 250) < 125) ? 70 : 30;
      vc = V'(1 << $urandom_range(0, V - 1));
      rd = V'(1 << $urandom_range(0, V - 1));
      if ($urandom_range(0, 15) == 0) vc = V'($urandom);
      if ($urandom_range(0, 15) == 0) rd = V'($urandom);
      apply_stimulus($urandom_range(0, 99) < 80, vc, $urandom_range(0, 99) < hdr_pct,
                     DSTPw'($urandom), $urandom_range(0, 99) < 60 ? rd : '0,
                     $urandom_range(0, 99) < (100 - hdr_pct));
    end
    @(negedge clk);
    idle_inputs();

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: actual pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lk_destport_queue.md
# lk_destport_queue

Per-input-port queue of look-ahead destination ports, one FIFO per virtual channel. It sits at a router input port, downstream of the look-ahead routing stage of the upstream router. On each arriving header flit it captures the precomputed `lkdestport` field. It presents that value to the local switch allocator for every flit of the packet, and retires it when the packet's tail flit leaves the VC buffer. Several packets can be queued back-to-back in one VC buffer, so each VC keeps its own route FIFO.

## Interface
Parameters:
- `V`, 4: number of virtual channels per port.
- `DSTPw`, 4: width of the encoded destination-port field (`P-1` for mesh/torus).
- `MAX_PKT`, 4: route entries per VC (≥2). Equals the maximum number of packets resident in one VC buffer.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-low.
- `flit_in_wr`  in  1: flit written into the input buffer this cycle.
- `vc_num_in`  in  V: one-hot VC of the incoming flit.
- `hdr_flg_in`  in  1: incoming flit is a header.
- `lkdestport_in`  in  DSTPw: look-ahead destport carried in the header.
- `ivc_rd`  in  V: one-hot VC whose head flit is read out this cycle.
- `tail_flg_out`  in  1: the flit being read is a tail (single-flit packets have header and tail set).
- `destport_out`  out  V*DSTPw: per-VC head-of-queue destport; VC `i` is at `[(i+1)*DSTPw-1 : i*DSTPw]`.
- `destport_vld`  out  V: per-VC queue non-empty.
- `ovf_err`  out  V: sticky; header arrived on a full VC queue.
- `udf_err`  out  V: sticky; tail read from an empty VC queue.

## Operation
- Per VC: storage array `MAX_PKT x DSTPw`, write pointer, read pointer, occupancy counter of width `log2(MAX_PKT+1)`.
- Pointers wrap explicitly at `MAX_PKT-1 -> 0`, so non-power-of-two depths are legal.
- **Push:** `flit_in_wr & hdr_flg_in & vc_num_in[i]`. Write `lkdestport_in` at `wr_ptr`, increment `wr_ptr` and count.
- **Pop:** `ivc_rd[i] & tail_flg_out`. Increment `rd_ptr`, decrement count. Body and header reads without the tail flag do not pop.
- **Simultaneous push and pop on the same VC:** both take effect and the count is unchanged. This also holds when full: the pop frees the slot the push uses, and no overflow is raised.
- **Push when full with no pop:** entry dropped, pointers and count unchanged, `ovf_err[i]` set.
- **Pop when empty:** no state change, `udf_err[i]` set. A push in the same cycle on an empty queue is not forwarded, so that pop is still an underflow.
- Error flags clear only on reset.
- A non-one-hot `vc_num_in` or `ivc_rd` acts on every asserted VC. This case is illegal upstream and is not checked here.
- `destport_out[i] = mem_i[rd_ptr_i]` (combinational read of registered storage). `destport_vld[i] = (count_i != 0)`.

## Timing
- Reset (async assert, sync release): pointers, counts and memory are 0, so `destport_out = 0`, `destport_vld = 0`, `ovf_err = 0`, `udf_err = 0`.
- Push-to-visible latency is 1 cycle: a header written in cycle N gives `destport_vld` and `destport_out` in cycle N+1.
- Pop takes effect at the clock edge. The next entry, if any, is visible in cycle N+1.
- Reset asserted mid-packet discards all entries immediately. The upstream buffer is reset at the same time.

## Structure
- Shared package holds the `log2` function and the `V` and `DSTPw` defaults, which come from the NoC parameter set.
- One sub-module, `destport_fifo`: single-VC FIFO with push, pop, head, valid, ovf and udf. It is instantiated V times in a generate loop. The top level only decodes push and pop per VC and concatenates the outputs.

## Test plan
- **Reset / basic push:** reset, then push header `lkdestport_in=4'b0010` on VC0 -> next cycle `destport_vld=4'b0001`, `destport_out[3:0]=4'b0010`; other VCs 0.
- **Multi-packet ordering:** VC2 pushes 1, 2, 3, then tails are read three times -> `destport_out[11:8]` shows 1, 2, 3 in order, then `destport_vld[2]=0`.
- **Single-flit packet:** hdr+tail written, then read one cycle later -> valid for exactly one cycle, no errors.
- **Full / overflow:** 4 pushes on VC1 with no pop, then a 5th -> `ovf_err[1]=1`, count stays 4, head unchanged. Repeat the 5th push with a simultaneous tail read -> no error, count stays 4.
- **Underflow:** tail read on empty VC3 -> `udf_err[3]=1` and remains set. Apply reset low mid-stream -> all outputs 0 asynchronously.
